// File: rtl/alu_pkg.sv
// Shared definitions for the ALU instruction path: R-type opcode, NOP word,
// instruction field slice positions and the instruction word type.
package alu_pkg;
  typedef logic [31:0] instr_t;

  localparam logic [5:0] OPCODE_RTYPE = 6'b000000;
  localparam instr_t     NOP_INSTR    = 32'h0000_0000;

  localparam int OP_MSB = 31, OP_LSB = 26;
  localparam int RS_MSB = 25, RS_LSB = 21;
  localparam int RT_MSB = 20, RT_LSB = 16;
  localparam int RD_MSB = 15, RD_LSB = 11;
  localparam int SH_MSB = 10, SH_LSB = 6;
  localparam int FN_MSB = 5,  FN_LSB = 0;

  function automatic logic is_rtype(instr_t w);
    return w[OP_MSB:OP_LSB] == OPCODE_RTYPE;
  endfunction
endpackage

// File: rtl/issue_fifo_mem.sv
// Circular storage behind the issue output slot. At most DEPTH-1 words are
// ever resident (the top keeps one in its output register), but the array is
// indexed by the full power-of-two pointer so wrap-around is a plain overflow.
module issue_fifo_mem
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   clr,
  input  logic   wr_en,
  input  instr_t wr_data,
  input  logic   rd_en,
  output instr_t rd_data
);
  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  instr_t        mem_q [DEPTH];
  instr_t        mem_d [DEPTH];

  // Next pointers and array contents; clear only rewinds the pointers.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_en) begin
        mem_d[wr_ptr_q] = wr_data;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // Pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Data array; contents are don't-care until written so no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rd_data = mem_q[rd_ptr_q];
endmodule

// File: rtl/alu_instr_issue.sv
// Issue queue in front of the register-file/ALU datapath. The head entry sits
// in a registered output slot (Instruction) that only changes on an issue, so
// the datapath result stays stable until the consumer takes it.
// Optional: define ISSUE_RTYPE_FILTER_EN to accept-and-drop non-R-type words.
module alu_instr_issue
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_instr,
  output logic [31:0]              Instruction,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic [7:0]               drop_count
);
  localparam int              CW   = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]   FULL = CW'(DEPTH);

  instr_t        instr_q, instr_d;
  logic          out_valid_q, out_valid_d;
  logic [CW-1:0] count_q, count_d;
  logic          keep, push, store, pop, slot_free, mem_empty;
  logic          mem_rd, mem_wr, bypass;
  instr_t        mem_rdata;

`ifdef ISSUE_RTYPE_FILTER_EN
  assign keep = is_rtype(in_instr);
`else
  assign keep = 1'b1;
`endif

  // Handshakes and routing: a stored word goes straight to the output slot
  // when the slot is (or is becoming) free and nothing older is buffered.
  always_comb begin
    in_ready  = (count_q != FULL);
    push      = in_valid && in_ready;
    store     = push && keep;
    pop       = out_valid_q && out_ready;
    slot_free = !out_valid_q || pop;
    mem_empty = (count_q == {{(CW-1){1'b0}}, out_valid_q});
    mem_rd    = slot_free && !mem_empty && !flush;
    bypass    = slot_free && mem_empty && store && !flush;
    mem_wr    = store && !bypass && !flush;
  end

  // Output slot and occupancy next-state.
  always_comb begin
    instr_d     = instr_q;
    out_valid_d = out_valid_q;
    count_d     = count_q;
    if (flush) begin
      out_valid_d = 1'b0;
      count_d     = '0;
    end else begin
      if (mem_rd) begin
        instr_d     = mem_rdata;
        out_valid_d = 1'b1;
      end else if (bypass) begin
        instr_d     = in_instr;
        out_valid_d = 1'b1;
      end else if (pop) begin
        out_valid_d = 1'b0;
      end
      if (store && !pop)      count_d = count_q + 1'b1;
      else if (!store && pop) count_d = count_q - 1'b1;
    end
  end

  // Output slot and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q     <= NOP_INSTR;
      out_valid_q <= 1'b0;
      count_q     <= '0;
    end else begin
      instr_q     <= instr_d;
      out_valid_q <= out_valid_d;
      count_q     <= count_d;
    end
  end

`ifdef ISSUE_RTYPE_FILTER_EN
  logic [7:0] drop_q, drop_d;

  // Saturating count of accepted-but-filtered words; frozen during flush.
  always_comb begin
    drop_d = drop_q;
    if (!flush && push && !keep && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
  end

  // Drop counter register.
  always_ff @(posedge clk) begin
    if (rst) drop_q <= 8'd0;
    else     drop_q <= drop_d;
  end

  assign drop_count = drop_q;
`else
  assign drop_count = 8'd0;
`endif

  issue_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .rst     (rst),
    .clr     (flush),
    .wr_en   (mem_wr),
    .wr_data (in_instr),
    .rd_en   (mem_rd),
    .rd_data (mem_rdata)
  );

  assign Instruction = instr_q;
  assign out_valid   = out_valid_q;
  assign count       = count_q;
endmodule

// File: tb/tb_alu_instr_issue.sv
// Self-checking bench for alu_instr_issue: directed scenarios plus a random
// run compared against a queue-based model of the issue queue.
module tb_alu_instr_issue;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] in_instr = '0;
  logic        in_ready, out_valid;
  logic [31:0] Instruction;
  logic [2:0]  count;
  logic [7:0]  drop_count;

  int n_pass = 0, n_total = 0;

  // Reference model: the whole queue contents, head first.
  logic [31:0] mq[$];
  logic [31:0] m_instr = '0;
  int          m_drop = 0;

  always #5 clk = ~clk;

  alu_instr_issue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .Instruction(Instruction), .out_valid(out_valid),
    .out_ready(out_ready), .count(count), .drop_count(drop_count)
  );

  function automatic bit keep_word(logic [31:0] w);
`ifdef ISSUE_RTYPE_FILTER_EN
    return w[31:26] == 6'b000000;
`else
    return 1'b1;
`endif
  endfunction

  // Apply one cycle of inputs, advance the model, land 1ns after the edge.
  task automatic drive_cycle(input bit r, input bit f, input bit iv,
                             input logic [31:0] ii, input bit ordy);
    bit acc, po;
    @(negedge clk);
    rst = r; flush = f; in_valid = iv; in_instr = ii; out_ready = ordy;
    @(posedge clk);
    if (r) begin
      mq.delete(); m_instr = '0; m_drop = 0;
    end else if (f) begin
      mq.delete();
    end else begin
      acc = iv && (mq.size() != DEPTH);
      po  = (mq.size() != 0) && ordy;
      if (po) void'(mq.pop_front());
      if (acc) begin
        if (keep_word(ii)) mq.push_back(ii);
        else if (m_drop < 255) m_drop++;
      end
    end
    if (mq.size() != 0) m_instr = mq[0];
    #1;
  endtask

  task automatic test_reset();
    drive_cycle(1, 0, 0, '0, 0);
    drive_cycle(1, 0, 1, 32'h0022_1820, 1);
    n_total++; if (Instruction !== 32'h0) $display("FAIL reset_instr got %h want 0", Instruction); else n_pass++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else n_pass++;
    n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else n_pass++;
    n_total++; if (count !== 3'd0) $display("FAIL reset_count got %0d want 0", count); else n_pass++;
    n_total++; if (drop_count !== 8'd0) $display("FAIL reset_drop got %0d want 0", drop_count); else n_pass++;
  endtask

  task automatic test_single_issue();
    drive_cycle(1, 0, 0, '0, 0);
    drive_cycle(0, 0, 1, 32'h0022_1820, 1);
    n_total++; if (out_valid !== 1'b1) $display("FAIL single_vld got %b want 1", out_valid); else n_pass++;
    n_total++; if (Instruction !== 32'h0022_1820) $display("FAIL single_instr got %h want 00221820", Instruction); else n_pass++;
    drive_cycle(0, 0, 0, '0, 1);
    n_total++; if (out_valid !== 1'b0) $display("FAIL single_vld_after got %b want 0", out_valid); else n_pass++;
    n_total++; if (Instruction !== 32'h0022_1820) $display("FAIL single_hold got %h want 00221820", Instruction); else n_pass++;
  endtask

  task automatic test_fill_drain();
    logic [31:0] w [5];
    w[0] = 32'h0022_1820; w[1] = 32'h0043_2022; w[2] = 32'h0064_2824;
    w[3] = 32'h0085_3025; w[4] = 32'h00A6_382A;
    drive_cycle(1, 0, 0, '0, 0);
    for (int i = 0; i < 4; i++) drive_cycle(0, 0, 1, w[i], 0);
    n_total++; if (count !== 3'd4) $display("FAIL fill_count got %0d want 4", count); else n_pass++;
    n_total++; if (in_ready !== 1'b0) $display("FAIL fill_in_ready got %b want 0", in_ready); else n_pass++;
    drive_cycle(0, 0, 1, w[4], 0);
    n_total++; if (count !== 3'd4 || Instruction !== w[0])
      $display("FAIL fill_stall got count=%0d instr=%h want count=4 instr=%h", count, Instruction, w[0]); else n_pass++;
    drive_cycle(0, 0, 1, w[4], 1);
    n_total++; if (Instruction !== w[1] || count !== 3'd3 || in_ready !== 1'b1)
      $display("FAIL drain_pop0 got instr=%h count=%0d rdy=%b want %h 3 1", Instruction, count, in_ready, w[1]); else n_pass++;
    drive_cycle(0, 0, 1, w[4], 1);
    n_total++; if (Instruction !== w[2] || count !== 3'd3)
      $display("FAIL drain_pop1 got instr=%h count=%0d want %h 3", Instruction, count, w[2]); else n_pass++;
    for (int i = 3; i < 5; i++) begin
      drive_cycle(0, 0, 0, '0, 1);
      n_total++; if (Instruction !== w[i] || out_valid !== 1'b1 || count !== 3'(5 - i))
        $display("FAIL drain_issue%0d got instr=%h vld=%b count=%0d want %h 1 %0d", i, Instruction, out_valid, count, w[i], 5 - i); else n_pass++;
    end
    drive_cycle(0, 0, 0, '0, 1);
    n_total++; if (out_valid !== 1'b0 || Instruction !== w[4] || count !== 3'd0)
      $display("FAIL drain_empty got vld=%b instr=%h count=%0d want 0 %h 0", out_valid, Instruction, count, w[4]); else n_pass++;
  endtask

  task automatic test_full_push_pop();
    drive_cycle(1, 0, 0, '0, 0);
    for (int i = 0; i < 4; i++) drive_cycle(0, 0, 1, {6'b0, 26'($urandom)}, 0);
    drive_cycle(0, 0, 1, 32'h0011_2020, 1);
    n_total++; if (count !== 3'd3) $display("FAIL fullpp_pop_only got count=%0d want 3", count); else n_pass++;
    drive_cycle(0, 0, 1, 32'h0011_2020, 0);
    n_total++; if (count !== 3'd4) $display("FAIL fullpp_push_next got count=%0d want 4", count); else n_pass++;
  endtask

  task automatic test_flush();
    drive_cycle(1, 0, 0, '0, 0);
    drive_cycle(0, 0, 1, 32'h0001_0820, 0);
    drive_cycle(0, 0, 1, 32'h0002_1020, 0);
    drive_cycle(0, 0, 1, 32'h0003_1820, 0);
    drive_cycle(0, 1, 1, 32'h00FF_F820, 1);
    n_total++; if (count !== 3'd0 || out_valid !== 1'b0)
      $display("FAIL flush_clear got count=%0d vld=%b want 0 0", count, out_valid); else n_pass++;
    n_total++; if (Instruction !== 32'h0001_0820) $display("FAIL flush_hold got %h want 00010820", Instruction); else n_pass++;
    drive_cycle(0, 0, 0, '0, 1);
    drive_cycle(0, 0, 0, '0, 1);
    n_total++; if (out_valid !== 1'b0 || Instruction !== 32'h0001_0820 || drop_count !== 8'd0)
      $display("FAIL flush_no_ghost got vld=%b instr=%h drop=%0d want 0 00010820 0", out_valid, Instruction, drop_count); else n_pass++;
  endtask

  task automatic test_filter();
    drive_cycle(1, 0, 0, '0, 0);
    drive_cycle(0, 0, 1, 32'h8C22_0000, 1);
`ifdef ISSUE_RTYPE_FILTER_EN
    n_total++; if (drop_count !== 8'd1 || count !== 3'd0 || out_valid !== 1'b0)
      $display("FAIL filter_one got drop=%0d count=%0d vld=%b want 1 0 0", drop_count, count, out_valid); else n_pass++;
    for (int i = 0; i < 300; i++) drive_cycle(0, 0, 1, 32'h8C22_0000, 1);
    n_total++; if (drop_count !== 8'd255 || count !== 3'd0 || Instruction !== 32'h0)
      $display("FAIL filter_sat got drop=%0d count=%0d instr=%h want 255 0 0", drop_count, count, Instruction); else n_pass++;
`else
    n_total++; if (drop_count !== 8'd0 || count !== 3'd1 || Instruction !== 32'h8C22_0000)
      $display("FAIL nofilter_store got drop=%0d count=%0d instr=%h want 0 1 8c220000", drop_count, count, Instruction); else n_pass++;
`endif
  endtask

  task automatic test_random();
    logic [31:0] w;
    drive_cycle(1, 0, 0, '0, 0);
    for (int c = 0; c < 600; c++) begin
      w = $urandom;
      if ($urandom_range(0, 9) < 7) w[31:26] = 6'b0;
      drive_cycle($urandom_range(0, 99) == 0, $urandom_range(0, 99) < 3,
                  $urandom_range(0, 1) == 1, w, $urandom_range(0, 2) != 0);
      n_total++;
      if (Instruction !== m_instr || out_valid !== (mq.size() != 0) ||
          count !== 3'(mq.size()) || in_ready !== (mq.size() != DEPTH) ||
          drop_count !== 8'(m_drop))
        $display("FAIL random_c%0d got instr=%h vld=%b cnt=%0d rdy=%b drop=%0d want %h %b %0d %b %0d",
                 c, Instruction, out_valid, count, in_ready, drop_count,
                 m_instr, mq.size() != 0, mq.size(), mq.size() != DEPTH, m_drop);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_single_issue();
    test_fill_drain();
    test_full_push_pop();
    test_flush();
    test_filter();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/alu_instr_issue.md
# alu_instr_issue

Instruction issue queue sitting directly upstream of the composite register-file/ALU datapath. Buffers 32-bit R-type instruction words from a producer (testbench or fetch logic) with a valid/ready handshake. Presents exactly one instruction at a time on a registered `Instruction` output that drives the datapath's instruction input, and advances on a downstream valid/ready handshake. The output is held stable between issues so the combinational result, zero and carry stay stable for the capturing stage.

## Interface
- `DEPTH`, 4: total entries, including the output slot; power of two, ≥2.
- `clk`  in  1  clock, rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  synchronous queue clear.
- `in_valid`  in  1  producer has `in_instr`.
- `in_ready`  out  1  queue can accept.
- `in_instr`  in  32  instruction word.
- `Instruction`  out  32  instruction presented to the datapath.
- `out_valid`  out  1  `Instruction` is a live, unconsumed entry.
- `out_ready`  in  1  downstream has captured the result for `Instruction`.
- `count`  out  $clog2(DEPTH)+1  occupancy, including the output slot.
- `drop_count`  out  8  filtered instructions; saturating.

## Operation
- Push occurs when `in_valid && in_ready`. Pop occurs when `out_valid && out_ready`.
- `in_ready = (count != DEPTH)`.
  - No push is accepted while full, even when a pop happens in the same cycle.
- Strict FIFO order. The head entry is loaded into the `Instruction` register.
- Empty queue:
  - `out_valid = 0`.
  - `Instruction` holds the last issued word and is never cleared by a pop.
- Simultaneous push and pop when not full: `count` is unchanged and order is preserved.
- `flush`:
  - Next cycle: `count = 0`, `out_valid = 0`.
  - `Instruction` holds its value.
  - A push in the flush cycle is discarded.
  - `drop_count` is unchanged.
- `rst`:
  - Overrides `flush` and any handshake.
  - All entries are discarded.
  - Applies mid-operation with no partial state retained.
- Reset values: `Instruction = 32'h0000_0000` (sll $0,$0,0, a NOP), `out_valid = 0`, `in_ready = 1`, `count = 0`, `drop_count = 0`.
- Pointers are `$clog2(DEPTH)` bits and wrap modulo DEPTH.

## Timing
- Push into an empty queue: `out_valid = 1` and `Instruction` updated on the next rising edge. Latency is 1 cycle.
- Pop with further entries queued: the next entry is on `Instruction` the cycle after the pop. Throughput is one issue per cycle.
- `in_ready` and `out_valid` are registered-state functions with no combinational path from `out_ready` to `in_ready`.
- `count` updates on the edge following the handshake.

## Configuration
- `ISSUE_RTYPE_FILTER_EN` defined:
  - A pushed word with `in_instr[31:26] != 6'b000000` is accepted (handshake completes) but not stored.
  - `drop_count` increments and saturates at 255.
  - `count` is not incremented.
- `ISSUE_RTYPE_FILTER_EN` undefined:
  - Every accepted word is stored.
  - `drop_count` is tied to 0.

## Structure
- Shared package `alu_pkg` holds:
  - `OPCODE_RTYPE = 6'b000000`.
  - `NOP_INSTR = 32'h0`.
  - Field slice constants: opcode [31:26], rs [25:21], rt [20:16], rd [15:11], shamt [10:6], funct [5:0].
  - Typedef `instr_t` (32-bit).
- One sub-module, `issue_fifo_mem`: DEPTH-1 entry circular storage with read/write pointers.
  - The top level owns the output register, count, filter and handshakes.

## Test plan
- Reset: assert `rst` 2 cycles → `Instruction = 0`, `out_valid = 0`, `in_ready = 1`, `count = 0`, `drop_count = 0`.
- Single issue: push `32'h0022_1820` with `out_ready = 1` → next cycle `out_valid = 1` and `Instruction = 32'h0022_1820`; the cycle after, `out_valid = 0` and `Instruction` still `32'h0022_1820`.
- Fill and drain:
  - With `out_ready = 0`, push words A, B, C, D → `count = 4`, `in_ready = 0`; a fifth push stalls.
  - Then hold `out_ready = 1` → A, B, C, D issue on consecutive cycles, and the fifth word is accepted after the first pop.
- Full with push and pop in the same cycle: `count = 4`, `in_valid = 1`, `out_ready = 1` → pop only, `count = 3`, push accepted on the following cycle.
- Flush with 3 entries plus a concurrent push → next cycle `count = 0` and `out_valid = 0`; the pushed word never appears.
- With `ISSUE_RTYPE_FILTER_EN`:
  - Push `32'h8C22_0000` → `drop_count = 1`, `count = 0`, never issued.
  - 300 such pushes → `drop_count = 255`.
